shift_ram_var: RTL



---
 rtl/shift_ram_var.sv | 128 ++++++++++++
 1 files changed

// File: rtl/shift_ram_var.sv
// Run-time programmable delay line (2..Depth enabled cycles) on a 1R1W RAM; SHIFT_RAM_VAR_ZERO_FILL_EN zeroes dout_data until primed.
// Latency: len_q enabled cycles, registered read; no backpressure, en simply stalls the line and dout_data holds.

module ram_1c_1r_1w #(
  parameter int Width = 8,
  parameter int Depth = 32,
  parameter int AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

module shift_ram_var #(
  parameter int Width = 8,
  parameter int Depth = 32,
  parameter int LenW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LenW-1:0]  len,
  input  logic             flush,
  input  logic             en,
  input  logic [Width-1:0] din_data,
  output logic [Width-1:0] dout_data,
  output logic             primed
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [LenW-1:0] LenMin   = LenW'(2);
  localparam logic [LenW-1:0] LenMax   = LenW'(Depth);
  localparam logic [LenW:0]   DepthExt = (LenW+1)'(Depth);
  localparam logic [AW-1:0]   AddrLast = AW'(Depth - 1);

  logic [LenW-1:0]  len_eff;
  logic [LenW-1:0]  len_q;
  logic [LenW-1:0]  fill_cnt;
  logic [LenW-1:0]  fill_inc;
  logic             len_chg;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    wr_addr_inc;
  logic [LenW:0]    rd_sum;
  logic [LenW:0]    rd_wrap;
  logic [AW-1:0]    rd_addr;
  logic [Width-1:0] ram_q;

  always_comb begin
    len_eff = len;
    if (len < LenMin)      len_eff = LenMin;
    else if (len > LenMax) len_eff = LenMax;
  end

  assign len_chg     = (len_eff != len_q);
  assign wr_en       = en & ~flush;
  assign fill_inc    = fill_cnt + 1'b1;
  assign wr_addr_inc = (wr_addr == AddrLast) ? '0 : wr_addr + 1'b1;

  // Biasing by Depth keeps the subtraction non-negative; one conditional
  // subtract then wraps, so Depth need not be a power of two.
  always_comb begin
    rd_sum  = (LenW+1)'(wr_addr) + DepthExt + {{LenW{1'b0}}, en} - {1'b0, len_q};
    rd_wrap = rd_sum;
    if (rd_sum >= DepthExt) rd_wrap = rd_sum - DepthExt;
    rd_addr = AW'(rd_wrap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr  <= '0;
      fill_cnt <= '0;
      len_q    <= LenMax;
      primed   <= 1'b0;
    end else if (flush) begin
      wr_addr  <= '0;
      fill_cnt <= '0;
      primed   <= 1'b0;
      if (len_chg) len_q <= len_eff;
    end else if (len_chg) begin
      // Old history is not trusted at the new length; the pointer keeps moving.
      len_q    <= len_eff;
      fill_cnt <= '0;
      primed   <= 1'b0;
      if (en) wr_addr <= wr_addr_inc;
    end else if (en) begin
      wr_addr <= wr_addr_inc;
      if (fill_cnt != len_q) begin
        fill_cnt <= fill_inc;
        primed   <= (fill_inc == len_q);
      end
    end
  end

  ram_1c_1r_1w #(
    .Width (Width),
    .Depth (Depth),
    .AddrW (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (din_data),
    .rd_en   (wr_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

`ifdef SHIFT_RAM_VAR_ZERO_FILL_EN
  // primed is itself a flop aligned with ram_q, so masking costs no latency.
  assign dout_data = primed ? ram_q : '0;
`else
  assign dout_data = ram_q;
`endif

endmodule
